dii_packet_buffer: RTL

// - Store-and-forward packet FIFO between a debug module's DII output and one debug ring input port.
// - Presents a packet to the ring only once it is completely buffered.
// - A ring port is therefore never held mid-packet by a slow producer.
// - Oversize packets (longer than BUF_SIZE) fall back to cut-through so the block never deadlocks.

---
 rtl/dii_packet_buffer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dii_packet_buffer.sv
// dii_packet_buffer: store-and-forward packet FIFO between a debug module's DII output and
// one debug ring input port. A packet is offered to the ring only once its last flit is
// buffered, so a slow producer never stalls the ring mid-packet. A packet longer than the
// buffer falls back to cut-through so the block cannot deadlock.
// Optional status outputs (o_pkt_count, o_free_slots) exist only when DII_PKTBUF_STATUS_EN
// is defined; the datapath and FSM are identical either way.
module dii_packet_buffer #(
  parameter  int unsigned BUF_SIZE = 8,
  localparam int unsigned PTR_W    = $clog2(BUF_SIZE)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  // Producer side
  input  logic            i_flit_valid,
  input  logic            i_flit_last,
  input  logic [15:0]     i_flit_data,
  output logic            o_flit_in_ready,
  // Ring side
  output logic            o_flit_valid,
  output logic            o_flit_last,
  output logic [15:0]     o_flit_data,
`ifdef DII_PKTBUF_STATUS_EN
  output logic [PTR_W:0]  o_pkt_count,
  output logic [PTR_W:0]  o_free_slots,
`endif
  input  logic            i_flit_out_ready
);

  localparam logic [PTR_W:0] FULL_FILL = (PTR_W + 1)'(BUF_SIZE);
  localparam logic [PTR_W:0] ONE       = (PTR_W + 1)'(1);

  typedef enum logic {StStore, StCut} state_e;

  state_e         r_state;
  state_e         w_state_nxt;
  logic [16:0]    r_mem [BUF_SIZE];
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  logic [PTR_W:0] r_pkt_cnt;

  logic [PTR_W:0] w_fill;
  logic           w_full;
  logic           w_empty;
  logic           w_wr_en;
  logic           w_rd_en;
  logic           w_wr_last;
  logic           w_rd_last;

  // Pointers carry a wrap bit so full and empty differ even with equal indices.
  assign w_fill  = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_fill == FULL_FILL);
  assign w_empty = (w_fill == '0);

  // No write-when-full bypass: a read in the same cycle does not free a slot early.
  assign o_flit_in_ready = !w_full && !i_rst;
  assign w_wr_en         = i_flit_valid && o_flit_in_ready;
  assign w_rd_en         = o_flit_valid && i_flit_out_ready;

  assign {o_flit_last, o_flit_data} = r_mem[r_rd_ptr[PTR_W-1:0]];

  assign w_wr_last = w_wr_en && i_flit_last;
  assign w_rd_last = w_rd_en && o_flit_last;

  // STORE offers data only when a whole packet is held; CUT streams whatever is present.
  assign o_flit_valid = (r_state == StCut) ? !w_empty : (r_pkt_cnt != '0);

`ifdef DII_PKTBUF_STATUS_EN
  assign o_pkt_count  = r_pkt_cnt;
  assign o_free_slots = FULL_FILL - w_fill;
`endif

  // Flit storage; no reset needed since contents are qualified by the pointers.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= {i_flit_last, i_flit_data};
    end
  end

  // Read/write pointers and count of complete packets held.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_pkt_cnt <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ONE;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + ONE;
      end
      if (w_wr_last && !w_rd_last) begin
        r_pkt_cnt <= r_pkt_cnt + ONE;
      end else if (!w_wr_last && w_rd_last) begin
        r_pkt_cnt <= r_pkt_cnt - ONE;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StStore;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: full with no complete packet means an oversize packet, so cut through
  // until its last flit leaves.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StStore: begin
        if (w_full && (r_pkt_cnt == '0)) begin
          w_state_nxt = StCut;
        end
      end
      StCut: begin
        if (w_rd_last) begin
          w_state_nxt = StStore;
        end
      end
    endcase
  end

endmodule
